// File: rtl/scan_chain_seq_ctrl_pkg.sv
// Shared types and helpers for the scan-chain sequencer: FSM state encoding,
// beat terminal-count helper and total sequence length for benches.
package scan_seq_pkg;

    localparam int DEF_CHAIN_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_FINISH  = 3'd4
    } seq_state_t;

    function automatic int beat_tc(input int chain_len);
        return chain_len - 1;
    endfunction

    // Cycles BUSY stays high; DONE is asserted in the last of them.
    function automatic int seq_len(input int chain_len, input int pat_cnt);
        return (pat_cnt == 0) ? 1 : pat_cnt * (chain_len + 1) + chain_len + 1;
    endfunction

endpackage

// File: rtl/scan_chain_seq_ctrl_if.sv
// Bundle between pattern engine / scan chain (master) and the sequencer (slave).
interface scan_chain_seq_if #(
    parameter int PAT_W = 8
) ();
    logic             start;
    logic [PAT_W-1:0] pat_cnt;
    logic             si_data;
    logic             si_valid;
    logic             si_ready;
    logic             si;
    logic             so;
    logic             se;
    logic             ce;
    logic             so_data;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pat_cnt, si_data, si_valid, so,
        input  si_ready, si, se, ce, so_data, so_valid, busy, done
    );

    modport slave (
        input  start, pat_cnt, si_data, si_valid, so,
        output si_ready, si, se, ce, so_data, so_valid, busy, done
    );
endinterface

// File: rtl/scan_chain_seq_ctrl_beat_counter.sv
// Shift-beat up-counter with enable, synchronous clear and terminal-count flag.
module scan_beat_counter #(
    parameter int BEAT_W = 4,
    parameter int TC_VAL = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [BEAT_W-1:0] r_beat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_beat <= '0;
        end else if (i_clr) begin
            r_beat <= '0;
        end else if (i_en) begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    assign o_tc = (r_beat == BEAT_W'(TC_VAL));
endmodule

// File: rtl/scan_chain_seq_ctrl.sv
// Scan-chain sequencer: serial load, one-cycle capture per pattern, final unload,
// with the first load's shifted-out bits marked as not meaningful.
module scan_chain_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int BEAT_W    = $clog2(CHAIN_LEN),
    parameter int PAT_W     = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    scan_chain_seq_if.slave bus
);
    localparam int BEAT_TC = beat_tc(CHAIN_LEN);

    seq_state_t       r_state;
    logic [PAT_W-1:0] r_remaining;
    logic             r_first;
    logic             r_se;
    logic             r_busy;
    logic             r_done;

    logic w_shift;
    logic w_beat;
    logic w_beat_en;
    logic w_beat_clr;
    logic w_tc;

    assign w_shift    = (r_state == ST_SHIFT);
    assign w_beat     = w_shift & bus.si_valid;
    assign w_beat_en  = w_beat | (r_state == ST_UNLOAD);
    // IDLE holds the counter at zero so every sequence starts on beat 0.
    assign w_beat_clr = (w_beat_en & w_tc) | (r_state == ST_IDLE);

    scan_beat_counter #(
        .BEAT_W (BEAT_W),
        .TC_VAL (BEAT_TC)
    ) u_beat (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_beat_clr),
        .i_en  (w_beat_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_first     <= 1'b1;
            r_se        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_remaining <= bus.pat_cnt;
                        r_first     <= 1'b1;
                        r_busy      <= 1'b1;
                        if (bus.pat_cnt != '0) begin
                            r_state <= ST_SHIFT;
                            r_se    <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_beat && w_tc) begin
                        r_state <= ST_CAPTURE;
                        r_se    <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_remaining <= r_remaining - PAT_W'(1);
                    r_first     <= 1'b0;
                    r_se        <= 1'b1;
                    r_state     <= (r_remaining == PAT_W'(1)) ? ST_UNLOAD : ST_SHIFT;
                end
                ST_UNLOAD: begin
                    if (w_tc) begin
                        r_state <= ST_FINISH;
                        r_se    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_se    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.se       = r_se;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.si_ready = w_shift;
    assign bus.ce       = w_beat | (r_state == ST_CAPTURE) | (r_state == ST_UNLOAD);
    assign bus.si       = w_beat & bus.si_data;
    // The very first load pushes out uninitialised chain contents.
    assign bus.so_valid = (w_beat & ~r_first) | (r_state == ST_UNLOAD);
    assign bus.so_data  = bus.so;
endmodule

// File: doc/scan_chain_seq_ctrl.md
Name: scan_chain_seq_ctrl

Overview:
- Sequencer that drives a scan chain built from the library's D flip-flops, fronted by scan muxes.
- Feeds the chain serially from a pattern source and sequences shift and capture.
- Emits the unloaded response bits and reports completion.
- Sits between an on-chip test/pattern engine and a CHAIN_LEN-deep flop chain; owns the chain's scan-enable and clock-enable.

Parameters:
- CHAIN_LEN, 16, number of flops in the chain (>=2).
- BEAT_W, $clog2(CHAIN_LEN), width of the shift-beat counter.
- PAT_W, 8, width of the pattern-count input.

Ports:
- CLK  in  1  rising-edge clock; chain flops share it.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- PAT_CNT  in  PAT_W  number of patterns; latched when START is accepted.
- SI_DATA  in  1  next serial pattern bit.
- SI_VALID  in  1  SI_DATA valid.
- SI_READY  out  1  controller accepts SI_DATA this cycle.
- SI  out  1  serial input to chain head.
- SO  in  1  chain tail Q.
- SE  out  1  scan enable to chain muxes: 1 = shift, 0 = functional capture.
- CE  out  1  clock enable for the chain; a chain edge occurs only when CE=1.
- SO_DATA  out  1  response bit (= SO).
- SO_VALID  out  1  SO_DATA is a meaningful response bit this cycle.
- BUSY  out  1  sequence in progress (state != IDLE).
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate): state=IDLE, beat=0, pattern count=0, first-load flag set. SE=CE=SI=SI_READY=SO_VALID=BUSY=DONE=0.
- Reset mid-operation aborts at once; chain contents are undefined and are not restored.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, FINISH.
- IDLE:
  - START=1 with PAT_CNT>0 -> SHIFT next cycle; latch remaining=PAT_CNT, beat=0, first=1.
  - START=1 with PAT_CNT=0 -> FINISH.
  - START while BUSY is ignored.
- SHIFT:
  - SE=1, SI_READY=1.
  - CE=SI_VALID (combinational). SI=SI_DATA when SI_VALID, else 0.
  - A beat is SI_VALID=1. On a beat, beat increments.
  - SO_VALID = SI_VALID & !first, so the first load discards SO.
  - Beat with beat==CHAIN_LEN-1 -> CAPTURE, beat=0.
  - SI_VALID=0 stalls: CE=0, counters hold, SE stays 1.
- CAPTURE (exactly 1 cycle): SE=0, CE=1, SI_READY=0, SO_VALID=0.
  - remaining decrements; first clears.
  - If remaining (pre-decrement)==1 -> UNLOAD, else -> SHIFT.
- UNLOAD (exactly CHAIN_LEN cycles, never stalls): SE=1, CE=1, SI=0, SO_VALID=1, SI_READY=0.
  - After beat==CHAIN_LEN-1 -> FINISH.
- FINISH (1 cycle): DONE=1, BUSY=1, all else 0 -> IDLE.
- SE, BUSY, DONE: Moore, from state. CE, SI, SI_READY, SO_VALID, SO_DATA: combinational from state, SI_VALID and SO.
- Latency, PAT_CNT=P with no stalls: DONE asserts P*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles after the START edge.
- Counters saturate-free: beat wraps 0..CHAIN_LEN-1 only under FSM control. remaining never underflows, because CAPTURE is entered only with remaining>=1.

Decomposition:
- Package scan_seq_pkg holds:
  - state enum typedef, 3-bit encoding, IDLE=0;
  - localparams for the beat terminal count;
  - a function computing total sequence length, for benches.
- One sub-module: scan_beat_counter. It is a BEAT_W up-counter with enable, synchronous clear, async RST, and a terminal-count flag at CHAIN_LEN-1.

Test Plan:
- Reset: RST=1 mid-SHIFT with CHAIN_LEN=4 -> same-cycle SE=CE=BUSY=SO_VALID=0. After release, IDLE; START/PAT_CNT=1 runs normally.
- CHAIN_LEN=4, PAT_CNT=1, SI_VALID=1 stream 1,0,1,1 -> 4 SHIFT beats with SO_VALID=0, then CAPTURE (SE=0,CE=1), then 4 UNLOAD beats with SO_VALID=1. DONE at cycle 10 after START.
- PAT_CNT=2 with a behavioural chain whose capture inverts each flop; load 1011 then 0000 -> SO_DATA beats 1 through 4 of pattern 2 equal the inverted first pattern in chain order. UNLOAD returns the inverted 0000 = 1111.
- Stall: SI_VALID low for 3 cycles after beat 2 -> CE=0 and SE=1 during the stall, beat holds at 2. Exactly 4 beats total; DONE is delayed by 3 cycles.
- PAT_CNT=0 -> DONE one cycle after START, CE never asserts, BUSY high for 1 cycle.
- START pulsed during UNLOAD -> ignored, no extra patterns. A second START after DONE restarts cleanly with first-load SO_VALID=0.
